// File: rtl/confreg_pkg.sv
// rtl/confreg_pkg.sv - shared state encoding, register offsets and base address for the confreg bridge
// Purpose: common definitions imported by confreg_bridge and by anything decoding confreg addresses.
// Contents: state_t (IDLE/ISSUE/CAPTURE/RESP), confreg register offsets, default upper address half.
package confreg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [15:0] LED_LO     = 16'h0000;
    localparam logic [15:0] LED_HI     = 16'h0004;
    localparam logic [15:0] NUM        = 16'h0008;
    localparam logic [15:0] SWITCH     = 16'h000c;
    localparam logic [15:0] SWITCH_DIP = 16'h0010;
    localparam logic [15:0] VUART      = 16'h0014;
    localparam logic [15:0] SWITCH_IN  = 16'h0018;

    // Upper 16 address bits that select the confreg window.
    localparam logic [15:0] BASE_HI    = 16'h1faf;

endpackage

// File: rtl/confreg_bridge.sv
// rtl/confreg_bridge.sv - valid/ready CPU data port to single-beat confreg SRAM-like access bridge
// Purpose: serialises one request at a time into a one-cycle conf_en pulse, waits out the
//          one-cycle registered read latency, captures read data and returns one response.
// Option : define CONFREG_BRIDGE_ERR_EN to reject requests whose req_addr[31:16] != BASE_HI
//          with resp_err=1 and no confreg access; otherwise resp_err is tied 0.
// Ports  : clk, rst_n (sync, active low)
//          req_valid/req_ready/req_wr/req_wstrb[3:0]/req_addr[31:0]/req_wdata[31:0]  request side
//          resp_valid/resp_ready/resp_rdata[31:0]/resp_err                           response side
//          conf_en/conf_wen[3:0]/conf_addr[31:0]/conf_wdata[31:0] out, conf_rdata[31:0] in
module confreg_bridge
    import confreg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        conf_en,
    output logic [3:0]  conf_wen,
    output logic [31:0] conf_addr,
    output logic [31:0] conf_wdata,
    input  logic [31:0] conf_rdata
);

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_reject;

    logic        r_wr;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_conf_en;
    logic [3:0]  r_conf_wen;
    logic [31:0] r_conf_addr;
    logic [31:0] r_conf_wdata;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
`ifdef CONFREG_BRIDGE_ERR_EN
                    if (req_addr[31:16] != BASE_HI) begin
                        w_reject = 1'b1;
                        w_next   = RESP;
                    end else
`endif
                    begin
                        w_accept = 1'b1;
                        w_next   = ISSUE;
                    end
                end
            end
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake and strobe outputs are registered from the next state so that
    // each one is high for exactly the cycles spent in its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr         <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_conf_en    <= 1'b0;
            r_conf_wen   <= 4'h0;
            r_conf_addr  <= 32'h0;
            r_conf_wdata <= 32'h0;
        end else begin
            r_state      <= w_next;
            r_req_ready  <= (w_next == IDLE);
            r_resp_valid <= (w_next == RESP);
            r_conf_en    <= (w_next == ISSUE);
            r_conf_wen   <= 4'h0;
            if (w_accept) begin
                r_wr         <= req_wr;
                r_conf_addr  <= req_addr;
                r_conf_wdata <= req_wdata;
                r_conf_wen   <= req_wr ? req_wstrb : 4'h0;
            end
            // conf_rdata is valid during CAPTURE for the address issued one cycle earlier.
            if (r_state == CAPTURE) begin
                r_resp_rdata <= r_wr ? 32'h0 : conf_rdata;
            end
            if (w_reject) begin
                r_resp_rdata <= 32'h0;
            end
        end
    end

`ifdef CONFREG_BRIDGE_ERR_EN
    logic r_resp_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_err <= 1'b0;
        end else if (w_reject) begin
            r_resp_err <= 1'b1;
        end else if (r_state == CAPTURE) begin
            r_resp_err <= 1'b0;
        end
    end

    assign resp_err = r_resp_err;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign conf_en    = r_conf_en;
    assign conf_wen   = r_conf_wen;
    assign conf_addr  = r_conf_addr;
    assign conf_wdata = r_conf_wdata;

endmodule

// File: tb/tb_confreg_bridge.sv
// tb/tb_confreg_bridge.sv - directed self-checking bench for confreg_bridge with a small confreg model
module tb_confreg_bridge;
    import confreg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        conf_en;
    logic [3:0]  conf_wen;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;

    logic [31:0] m_mem [0:7];
    logic [7:0]  sw;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    confreg_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_wstrb  (req_wstrb),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .conf_en    (conf_en),
        .conf_wen   (conf_wen),
        .conf_addr  (conf_addr),
        .conf_wdata (conf_wdata),
        .conf_rdata (conf_rdata)
    );

    // confreg responder model: one-cycle registered read, byte-enabled writes, switch is read-only.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_mem[i] <= 32'h0;
            m_mem[0]   <= 32'hdeadbeef;
            conf_rdata <= 32'h0;
        end else if (conf_en) begin
            for (int b = 0; b < 4; b++) begin
                if (conf_wen[b] && conf_addr[15:0] != SWITCH)
                    m_mem[conf_addr[4:2]][8*b +: 8] <= conf_wdata[8*b +: 8];
            end
            conf_rdata <= (conf_addr[15:0] == SWITCH) ? {24'h0, sw} : m_mem[conf_addr[4:2]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge (the accept edge k) and returns at k+1 (#1 after edge k).
    task automatic send_req(input logic wr, input logic [3:0] strb,
                            input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_wr    = wr;
        req_wstrb = strb;
        req_addr  = addr;
        req_wdata = data;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (conf_en !== 1'b0) begin failures++; $display("FAIL reset_conf_en got=%b exp=0", conf_en); end
        checks++; if (conf_wen !== 4'h0) begin failures++; $display("FAIL reset_conf_wen got=%h exp=0", conf_wen); end
        checks++; if (conf_addr !== 32'h0) begin failures++; $display("FAIL reset_conf_addr got=%h exp=0", conf_addr); end
        checks++; if (conf_wdata !== 32'h0) begin failures++; $display("FAIL reset_conf_wdata got=%h exp=0", conf_wdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        send_req(1'b1, 4'hf, 32'h1faf0008, 32'h12345678);
        checks++; if (conf_en !== 1'b1) begin failures++; $display("FAIL wr_issue_en got=%b exp=1", conf_en); end
        checks++; if (conf_wen !== 4'hf) begin failures++; $display("FAIL wr_issue_wen got=%h exp=f", conf_wen); end
        checks++; if (conf_addr !== 32'h1faf0008) begin failures++; $display("FAIL wr_issue_addr got=%h exp=1faf0008", conf_addr); end
        checks++; if (conf_wdata !== 32'h12345678) begin failures++; $display("FAIL wr_issue_wdata got=%h exp=12345678", conf_wdata); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL wr_issue_req_ready got=%b exp=0", req_ready); end
        step();
        checks++; if (conf_en !== 1'b0 || conf_wen !== 4'h0) begin failures++; $display("FAIL wr_capture_strobes got=%b/%h exp=0/0", conf_en, conf_wen); end
        checks++; if (conf_addr !== 32'h1faf0008) begin failures++; $display("FAIL wr_capture_addr_hold got=%h exp=1faf0008", conf_addr); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL wr_capture_resp_valid got=%b exp=0", resp_valid); end
        step();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL wr_resp_valid got=%b exp=1", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL wr_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL wr_resp_err got=%b exp=0", resp_err); end
        step();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL wr_done got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
        send_req(1'b0, 4'h0, 32'h1faf0008, 32'h0);
        checks++; if (conf_wen !== 4'h0) begin failures++; $display("FAIL rd_num_wen got=%h exp=0", conf_wen); end
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678) begin failures++; $display("FAIL rd_num_data got valid=%b data=%h exp 1/12345678", resp_valid, resp_rdata); end
        step();
    endtask

    task automatic test_read_switch();
        sw = 8'hA5;
        send_req(1'b0, 4'hf, 32'h1faf000c, 32'hffffffff);
        checks++; if (conf_en !== 1'b1 || conf_wen !== 4'h0) begin failures++; $display("FAIL sw_issue got en=%b wen=%h exp 1/0", conf_en, conf_wen); end
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000a5) begin failures++; $display("FAIL sw_resp got valid=%b data=%h exp 1/000000a5", resp_valid, resp_rdata); end
        step();
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        send_req(1'b0, 4'h0, 32'h1faf0008, 32'h0);
        step();
        step();
        // Second request presented while the first response is stalled.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_wstrb = 4'hf;
        req_addr  = 32'h1faf0014;
        req_wdata = 32'h00000055;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678) begin failures++; $display("FAIL bp_hold_%0d got valid=%b data=%h exp 1/12345678", i, resp_valid, resp_rdata); end
            checks++; if (req_ready !== 1'b0 || conf_en !== 1'b0) begin failures++; $display("FAIL bp_block_%0d got ready=%b en=%b exp 0/0", i, req_ready, conf_en); end
            step();
        end
        resp_ready = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || conf_en !== 1'b0) begin failures++; $display("FAIL bp_release got ready=%b valid=%b en=%b exp 1/0/0", req_ready, resp_valid, conf_en); end
        step();
        req_valid = 1'b0;
        checks++; if (conf_en !== 1'b1 || conf_addr !== 32'h1faf0014 || conf_wen !== 4'hf) begin failures++; $display("FAIL bp_second_issue got en=%b addr=%h wen=%h exp 1/1faf0014/f", conf_en, conf_addr, conf_wen); end
        step();
        step();
        step();
    endtask

    task automatic test_zero_strobe();
        send_req(1'b1, 4'h0, 32'h1faf0000, 32'hffffffff);
        checks++; if (conf_en !== 1'b1 || conf_wen !== 4'h0) begin failures++; $display("FAIL zs_issue got en=%b wen=%h exp 1/0", conf_en, conf_wen); end
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin failures++; $display("FAIL zs_resp got valid=%b data=%h exp 1/0", resp_valid, resp_rdata); end
        step();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL zs_single_resp got=%b exp=0", resp_valid); end
        send_req(1'b0, 4'h0, 32'h1faf0000, 32'h0);
        step();
        step();
        checks++; if (resp_rdata !== 32'hdeadbeef) begin failures++; $display("FAIL zs_led_unchanged got=%h exp=deadbeef", resp_rdata); end
        step();
    endtask

    task automatic test_addr_range();
        send_req(1'b0, 4'h0, 32'h1fb00000, 32'h0);
`ifdef CONFREG_BRIDGE_ERR_EN
        checks++; if (conf_en !== 1'b0) begin failures++; $display("FAIL err_no_en got=%b exp=0", conf_en); end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin failures++; $display("FAIL err_resp got valid=%b err=%b data=%h exp 1/1/0", resp_valid, resp_err, resp_rdata); end
        step();
        checks++; if (req_ready !== 1'b1 || conf_en !== 1'b0) begin failures++; $display("FAIL err_done got ready=%b en=%b exp 1/0", req_ready, conf_en); end
`else
        checks++; if (conf_en !== 1'b1) begin failures++; $display("FAIL far_en got=%b exp=1", conf_en); end
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin failures++; $display("FAIL far_resp got valid=%b err=%b exp 1/0", resp_valid, resp_err); end
        step();
`endif
    endtask

    task automatic test_back_to_back();
        int n_en;
        int n_resp;
        n_en   = 0;
        n_resp = 0;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_wstrb = 4'h0;
        req_addr  = 32'h1faf0008;
        for (int i = 0; i < 12; i++) begin
            step();
            if (conf_en === 1'b1) n_en++;
            if (resp_valid === 1'b1) n_resp++;
        end
        req_valid = 1'b0;
        checks++; if (n_en !== 3) begin failures++; $display("FAIL b2b_issues got=%0d exp=3", n_en); end
        checks++; if (n_resp !== 3) begin failures++; $display("FAIL b2b_resps got=%0d exp=3", n_resp); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid_resp();
        resp_ready = 1'b0;
        send_req(1'b0, 4'h0, 32'h1faf0008, 32'h0);
        step();
        step();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", resp_valid); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_rst got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
        checks++; if (conf_en !== 1'b0 || conf_wen !== 4'h0 || conf_addr !== 32'h0 || conf_wdata !== 32'h0) begin failures++; $display("FAIL mid_rst_conf got en=%b wen=%h addr=%h wdata=%h exp all 0", conf_en, conf_wen, conf_addr, conf_wdata); end
        resp_ready = 1'b1;
        step();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_dropped got=%b exp=0", resp_valid); end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_wstrb  = 4'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        sw         = 8'h00;
        #1;
        test_reset();
        test_write();
        test_read_switch();
        test_backpressure();
        test_zero_strobe();
        test_addr_range();
        test_back_to_back();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/confreg_bridge.md
# confreg_bridge

Initiator-side bridge that converts CPU data-port valid/ready transactions into single-beat accesses on the confreg SRAM-like interface (conf_en/conf_wen/conf_addr/conf_wdata in, conf_rdata out with one-cycle registered read latency). Sits between the CPU data-side crossbar and the confreg responder. It serialises requests, holds the address stable across the read-latency cycle, captures read data, and returns one response per request.

## Interface
- BASE_HI, 16'h1faf: required value of req_addr[31:16] for an in-range access (used only with the error feature).
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept; high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_wstrb  in  4  byte enables for writes; ignored for reads
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  read data; 0 for writes
- resp_err  out  1  out-of-range access (error feature only; else constant 0)
- conf_en  out  1  access strobe to confreg
- conf_wen  out  4  write enables to confreg
- conf_addr  out  32  address to confreg
- conf_wdata  out  32  write data to confreg
- conf_rdata  in  32  registered read data from confreg

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid: latch req_wr, req_wstrb, req_addr, req_wdata; go to ISSUE. If the error feature rejects the address, go to RESP with resp_err=1.
- ISSUE: conf_en=1 for exactly one cycle; conf_wen = latched wstrb if wr, else 4'b0; conf_addr/conf_wdata = latched values. Go to CAPTURE.
- CAPTURE: conf_en=0, conf_wen=0, conf_addr held at latched value. At cycle end resp_rdata <= (wr ? 0 : conf_rdata), resp_err <= 0. Go to RESP.
- RESP: resp_valid=1, resp_rdata/resp_err stable. On resp_ready go to IDLE; otherwise hold indefinitely.
- A write with wstrb=4'b0 still passes through all states with conf_en=1, conf_wen=0 and returns a response. Its resp_rdata is 0.
- Exactly one transaction is outstanding. No new request is accepted before the response handshake completes. Back-to-back throughput is one transaction per 4 cycles with resp_ready held high.
- conf_en is never asserted outside ISSUE. conf_wen is nonzero only in ISSUE.

## Timing
- Reset (rst_n=0 at posedge): state=IDLE; req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_err=0, conf_en=0, conf_wen=0, conf_addr=0, conf_wdata=0. All outputs are registered.
- Request accepted at edge k. ISSUE occupies cycle k+1 (conf_en high). CAPTURE occupies cycle k+2, with conf_rdata valid for the latched address. resp_valid is high from cycle k+3.
- Error path: resp_valid is high from cycle k+1. No conf_en pulse is issued.
- Reset asserted mid-transaction (any state): the FSM returns to IDLE and any pending response is dropped. If reset lands in ISSUE, the write may or may not have reached confreg; the bench must not check its effect.
- req_valid while not in IDLE is ignored; req_* need not be held by the bridge.

## Configuration
- CONFREG_BRIDGE_ERR_EN defined: in IDLE, a request with req_addr[31:16] != BASE_HI goes straight to RESP with resp_err=1 and resp_rdata=0. confreg is never touched.
- CONFREG_BRIDGE_ERR_EN undefined: every request is forwarded regardless of address. resp_err is tied 0, and the compare logic and BASE_HI use are compiled out.

## Structure
- Shared package confreg_pkg holds:
  - the state enum typedef (IDLE, ISSUE, CAPTURE, RESP);
  - localparams for the register offsets (LED_LO 16'h0000, LED_HI 16'h0004, NUM 16'h0008, SWITCH 16'h000c, SWITCH_DIP 16'h0010, VUART 16'h0014, SWITCH_IN 16'h0018);
  - the default base 16'h1faf.
- No sub-module. FSM, request latch and response register live in one module.

## Test plan
- Reset then write: req wr=1, wstrb=4'hf, addr=32'h1faf0008, wdata=32'h12345678. Expect:
  - conf_en=1, conf_wen=4'hf, conf_addr=32'h1faf0008 for one cycle at k+1;
  - resp_valid at k+3 with resp_rdata=0;
  - a later read of 32'h1faf0008 returns 32'h12345678.
- Read switch: switch=8'hA5, read 32'h1faf000c. Expect conf_en pulse with conf_wen=0 and resp_rdata=32'h000000A5 at k+3.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid. Expect resp_valid/resp_rdata stable, req_ready=0, and a second req_valid not accepted. Raise resp_ready: state returns to IDLE and the second request is accepted next cycle.
- Zero-strobe write: wr=1, wstrb=0 to 32'h1faf0000. Expect conf_en=1, conf_wen=0, LED_LO unchanged, and one response.
- With CONFREG_BRIDGE_ERR_EN: read 32'h1fb00000. Expect no conf_en, resp_valid at k+1 with resp_err=1 and resp_rdata=0. Without the macro, expect a conf_en pulse and resp_err=0.
- Reset mid-RESP: resp_valid=1, then rst_n=0 for one cycle. Expect resp_valid=0, req_ready=1 next cycle and all conf_* outputs 0.
